// File: rtl/ahb_sram_pkg.sv
// Shared types and bus encodings for the AHB-Lite SRAM slave.
package ahb_sram_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    LAST = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } state_t;

  localparam logic HRESP_OKAY    = 1'b0;
  localparam logic HRESP_ERROR   = 1'b1;
  localparam logic HTRANS_IDLE   = 1'b0;
  localparam logic HTRANS_ACTIVE = 1'b1;

endpackage

// File: rtl/ahb_sram_regfile.sv
// Word storage: synchronous write, asynchronous read, synchronous clear of every word.
module ahb_sram_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Clear wins over a pending write so an aborted transfer never lands.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address decode, wait-state/error FSM and data-phase muxing.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 64,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_hselx,
  input  logic                  i_htrans,
  input  logic                  i_hwrite,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic [DATA_WIDTH-1:0] o_hrdata,
  output logic                  o_hresp,
  output state_t                o_dbg_state
);

  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT   = (ADDR_WIDTH + 1)'(DEPTH * 4);
  localparam logic [2:0]          WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic                  accept;
  logic                  take;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Below-base addresses wrap to huge offsets and fall out of the window.
  assign offset   = i_haddr - BASE_ADDR;
  assign addr_err = (i_haddr[1:0] != 2'b00) || ({1'b0, offset} >= LIMIT);
  assign accept   = i_hselx && (i_htrans == HTRANS_ACTIVE) && i_hready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    idx_d       = idx_q;
    take        = 1'b0;
    o_hreadyout = 1'b1;
    o_hresp     = HRESP_OKAY;
    o_hrdata    = '0;

    case (state_q)
      IDLE: take = accept;
      WAIT: begin
        o_hreadyout = 1'b0;
        if (cnt_q == 3'd0) state_d = LAST;
        else               cnt_d   = cnt_q - 3'd1;
      end
      LAST: begin
        if (!write_q) o_hrdata = mem_rdata;
        state_d = IDLE;
        take    = accept;
      end
      ERR1: begin
        o_hreadyout = 1'b0;
        o_hresp     = HRESP_ERROR;
        state_d     = ERR2;
      end
      ERR2: begin
        o_hresp = HRESP_ERROR;
        state_d = IDLE;
        take    = accept;
      end
      default: state_d = IDLE;
    endcase

    // A new address phase may be taken only when the previous data phase is ending.
    if (take) begin
      write_d = i_hwrite;
      idx_d   = offset[IDX_W+1:2];
      if (addr_err) begin
        state_d = ERR1;
      end else if (WAIT_STATES == 0) begin
        state_d = LAST;
      end else begin
        state_d = WAIT;
        cnt_d   = WS_INIT;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
    end
  end

  // Write lands on the edge closing LAST, ahead of any following read data phase.
  assign mem_we      = (state_q == LAST) && write_q;
  assign o_dbg_state = state_q;

  ahb_sram_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_clear (i_reset),
    .i_we    (mem_we),
    .i_waddr (idx_q),
    .i_wdata (i_hwdata),
    .i_raddr (idx_q),
    .o_rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one zero-wait and one three-wait instance driven from a shared clock/reset.
module tb_ahb_sram_slave;
  import ahb_sram_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        hsel       [2];
  logic        htrans     [2];
  logic        hwrite     [2];
  logic        hready_ext [2];
  logic [31:0] haddr      [2];
  logic [31:0] hwdata     [2];
  logic        hready     [2];
  logic        hreadyout  [2];
  logic        hresp      [2];
  logic [31:0] hrdata     [2];
  state_t      dbg        [2];

  // Single-slave bus: the slave's own ready feeds back, gated by an external stall.
  assign hready[0] = hreadyout[0] & hready_ext[0];
  assign hready[1] = hreadyout[1] & hready_ext[1];

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_ws0 (
    .i_clk(clk), .i_reset(rst), .i_hselx(hsel[0]), .i_htrans(htrans[0]),
    .i_hwrite(hwrite[0]), .i_haddr(haddr[0]), .i_hwdata(hwdata[0]), .i_hready(hready[0]),
    .o_hreadyout(hreadyout[0]), .o_hrdata(hrdata[0]), .o_hresp(hresp[0]), .o_dbg_state(dbg[0])
  );

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(BASE)) u_ws3 (
    .i_clk(clk), .i_reset(rst), .i_hselx(hsel[1]), .i_htrans(htrans[1]),
    .i_hwrite(hwrite[1]), .i_haddr(haddr[1]), .i_hwdata(hwdata[1]), .i_hready(hready[1]),
    .o_hreadyout(hreadyout[1]), .o_hrdata(hrdata[1]), .o_hresp(hresp[1]), .o_dbg_state(dbg[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic addr_phase(input int k, input logic wr, input logic [31:0] a);
    hsel[k]   = 1'b1;
    htrans[k] = HTRANS_ACTIVE;
    hwrite[k] = wr;
    haddr[k]  = a;
  endtask

  task automatic addr_idle(input int k);
    hsel[k]   = 1'b0;
    htrans[k] = HTRANS_IDLE;
    hwrite[k] = 1'b0;
    haddr[k]  = '0;
  endtask

  task automatic expect_bus(input int k, input string tag, input logic rdy, input logic resp,
                            input logic [31:0] rd);
    check({tag, ".rdy"},  hreadyout[k], rdy);
    check({tag, ".resp"}, hresp[k],     resp);
    check({tag, ".data"}, hrdata[k],    rd);
  endtask

  // Leaves the bench at the falling edge of the first cycle with hreadyout high.
  task automatic wait_ready(input int k, output int lows);
    lows = 0;
    at_neg();
    while (!hreadyout[k] && lows < 16) begin
      lows++;
      tick();
      at_neg();
    end
    if (lows >= 16) check("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_read(input int k, input logic [31:0] a, output logic [31:0] d);
    int lows;
    tick();
    addr_phase(k, 1'b0, a);
    tick();
    addr_idle(k);
    wait_ready(k, lows);
    d = hrdata[k];
  endtask

  task automatic do_error(input int k, input logic wr, input logic [31:0] a, input string tag);
    tick();
    addr_phase(k, wr, a);
    tick();
    addr_idle(k);
    hwdata[k] = 32'hFFFF_FFFF;
    at_neg();
    expect_bus(k, {tag, ".c1"}, 1'b0, 1'b1, 32'h0);
    check({tag, ".st1"}, dbg[k], ERR1);
    tick();
    at_neg();
    expect_bus(k, {tag, ".c2"}, 1'b1, 1'b1, 32'h0);
    hwdata[k] = '0;
  endtask

  logic [31:0] rd;
  int          lows;
  logic [31:0] err_addr [3];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      addr_idle(k);
      hwdata[k]     = '0;
      hready_ext[k] = 1'b1;
    end
    rst = 1'b1;
    tick();
    tick();
    at_neg();
    for (int k = 0; k < 2; k++) begin
      expect_bus(k, "reset", 1'b1, 1'b0, 32'h0);
      check("reset.st", dbg[k], IDLE);
    end
    rst = 1'b0;

    // Zero-wait write then back-to-back read of the same word.
    tick();
    addr_phase(0, 1'b1, BASE + 32'h4);
    at_neg();
    expect_bus(0, "rw.addr", 1'b1, 1'b0, 32'h0);
    tick();
    hwdata[0] = 32'hA5A5_0001;
    addr_phase(0, 1'b0, BASE + 32'h4);
    at_neg();
    expect_bus(0, "rw.wdata", 1'b1, 1'b0, 32'h0);
    check("rw.st", dbg[0], LAST);
    tick();
    addr_idle(0);
    hwdata[0] = '0;
    at_neg();
    expect_bus(0, "rw.rdata", 1'b1, 1'b0, 32'hA5A5_0001);
    tick();
    at_neg();
    expect_bus(0, "rw.end", 1'b1, 1'b0, 32'h0);
    check("rw.idle", dbg[0], IDLE);

    // Three wait states on a fresh read.
    tick();
    addr_phase(1, 1'b0, BASE + 32'h8);
    tick();
    addr_idle(1);
    wait_ready(1, lows);
    check("ws.lows", lows, 32'd3);
    expect_bus(1, "ws.rd", 1'b1, 1'b0, 32'h0);
    check("ws.st", dbg[1], LAST);

    // Waited write followed by a read accepted on the write's final edge.
    tick();
    addr_phase(1, 1'b1, BASE + 32'h10);
    tick();
    hwdata[1] = 32'h1234_5678;
    addr_phase(1, 1'b0, BASE + 32'h10);
    wait_ready(1, lows);
    check("ws2.wlows", lows, 32'd3);
    tick();
    addr_idle(1);
    hwdata[1] = '0;
    wait_ready(1, lows);
    check("ws2.rlows", lows, 32'd3);
    expect_bus(1, "ws2.rd", 1'b1, 1'b0, 32'h1234_5678);

    // Out-of-window, misaligned and below-base writes all error and store nothing.
    err_addr[0] = BASE + 32'(DEPTH * 4);
    err_addr[1] = BASE + 32'h2;
    err_addr[2] = BASE - 32'h4;
    for (int i = 0; i < 3; i++) begin
      do_error(0, 1'b1, err_addr[i], $sformatf("err%0d", i));
    end
    do_error(1, 1'b1, err_addr[0], "err3w");
    do_read(0, BASE + 32'h0, rd);
    check("err.mem0", rd, 32'h0);
    do_read(0, BASE + 32'hFC, rd);
    check("err.mem63", rd, 32'h0);
    do_read(0, BASE + 32'h4, rd);
    check("err.mem1", rd, 32'hA5A5_0001);
    do_read(1, BASE + 32'h0, rd);
    check("err3w.mem0", rd, 32'h0);

    // Error followed by a transfer accepted during ERR2 with no idle gap.
    tick();
    addr_phase(0, 1'b0, BASE + 32'(DEPTH * 4));
    tick();
    addr_phase(0, 1'b1, BASE + 32'h0);
    at_neg();
    expect_bus(0, "e2b.c1", 1'b0, 1'b1, 32'h0);
    tick();
    at_neg();
    expect_bus(0, "e2b.c2", 1'b1, 1'b1, 32'h0);
    check("e2b.st2", dbg[0], ERR2);
    tick();
    addr_idle(0);
    hwdata[0] = 32'h0BAD_F00D;
    at_neg();
    expect_bus(0, "e2b.ok", 1'b1, 1'b0, 32'h0);
    check("e2b.st", dbg[0], LAST);
    do_read(0, BASE + 32'h0, rd);
    check("e2b.mem", rd, 32'h0BAD_F00D);

    // Address phase stalled by hready low for two edges, taken on the third.
    tick();
    hready_ext[0] = 1'b0;
    addr_phase(0, 1'b0, BASE + 32'h4);
    at_neg();
    check("stall.st0", dbg[0], IDLE);
    tick();
    at_neg();
    check("stall.st1", dbg[0], IDLE);
    tick();
    hready_ext[0] = 1'b1;
    at_neg();
    check("stall.st2", dbg[0], IDLE);
    tick();
    addr_idle(0);
    at_neg();
    check("stall.acc", dbg[0], LAST);
    expect_bus(0, "stall.rd", 1'b1, 1'b0, 32'hA5A5_0001);

    // Reset during a waited write and during ERR1 aborts both transfers.
    tick();
    addr_phase(1, 1'b1, BASE + 32'hC);
    addr_phase(0, 1'b0, BASE + 32'h2);
    tick();
    addr_idle(1);
    addr_idle(0);
    hwdata[1] = 32'hDEAD_BEEF;
    at_neg();
    check("rst.wait", dbg[1], WAIT);
    check("rst.err1", dbg[0], ERR1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hwdata[1] = '0;
    at_neg();
    expect_bus(1, "rst.ws3", 1'b1, 1'b0, 32'h0);
    expect_bus(0, "rst.ws0", 1'b1, 1'b0, 32'h0);
    check("rst.st3", dbg[1], IDLE);
    check("rst.st0", dbg[0], IDLE);
    do_read(1, BASE + 32'hC, rd);
    check("rst.memC", rd, 32'h0);
    do_read(0, BASE + 32'h4, rd);
    check("rst.mem4", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 32, the address bus width.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, the data bus width.
REQ-003 The block SHALL take parameter DEPTH, default 64, the number of DATA_WIDTH words of storage.
REQ-004 The block SHALL take parameter WAIT_STATES, default 0 (range 0..7), the number of low-hreadyout cycles per OKAY data phase.
REQ-005 The block SHALL take parameter BASE_ADDR, default 32'h0, the start address of the window.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset, with ports: i_clk input 1 (clock); i_reset input 1 (synchronous active-high reset).
REQ-007 Slave-side inputs: i_hselx 1 (slot select); i_htrans 1 (1=active transfer); i_hwrite 1; i_haddr ADDR_WIDTH; i_hwdata DATA_WIDTH; i_hready 1 (bus-wide ready).
REQ-008 Slave-side outputs: o_hreadyout 1; o_hrdata DATA_WIDTH; o_hresp 1 (0=OKAY, 1=ERROR).

Function
REQ-009 A transfer SHALL be accepted on a rising edge where i_hselx & i_htrans & i_hready = 1; address, write flag and word offset are registered then.
REQ-010 An accepted transfer SHALL be in error if i_haddr[1:0] != 0 or (i_haddr - BASE_ADDR) >= DEPTH*4, with unsigned ADDR_WIDTH subtraction; below-base addresses wrap and so fail.
REQ-011 The FSM SHALL have states IDLE, WAIT, LAST, ERR1 and ERR2.
REQ-012 On an OKAY accept, the FSM SHALL enter WAIT with the counter at WAIT_STATES-1, or enter LAST directly when WAIT_STATES=0.
REQ-013 On an error accept, the FSM SHALL enter ERR1.
REQ-014 WAIT SHALL decrement the counter each cycle and go to LAST when it reads 0; o_hreadyout=0 and o_hresp=0 in WAIT.
REQ-015 In LAST, o_hreadyout SHALL be 1 and o_hresp 0; for a read, o_hrdata SHALL equal mem[offset]; otherwise o_hrdata SHALL be 0.
REQ-016 A write SHALL commit i_hwdata to mem[offset] on the edge that ends LAST; memory SHALL never change on error transfers.
REQ-017 ERR1 SHALL drive o_hreadyout=0 and o_hresp=1, and ERR2 SHALL drive o_hreadyout=1 and o_hresp=1, giving the two-cycle AHB error response.
REQ-018 On leaving LAST or ERR2, the FSM SHALL go to the next state per REQ-012/013 if a new transfer is accepted on that edge, else to IDLE.
REQ-019 Back-to-back transfers SHALL carry no dead cycle.
REQ-020 In IDLE, o_hreadyout SHALL be 1, o_hresp 0 and o_hrdata 0.
REQ-021 A non-selected or idle cycle with i_hready=1 SHALL leave the FSM in IDLE with a zero-wait OKAY response.
REQ-022 Read-after-write to the same word SHALL return the new data with no forwarding logic, because the commit edge precedes the read data phase.
REQ-023 Address-phase inputs SHALL be ignored while i_hready=0.

Reset
REQ-024 While i_reset=1 at an edge: FSM=IDLE, counter=0, stored address/flags=0, all DEPTH words=0, o_hreadyout=1, o_hresp=0, o_hrdata=0.
REQ-025 Reset mid-transfer, including mid-WAIT and ERR1, SHALL abort the transfer with no memory write; the first cycle after reset SHALL behave as IDLE.

Structure
REQ-026 Package ahb_sram_pkg SHALL hold the state enum (IDLE, WAIT, LAST, ERR1, ERR2), HRESP_OKAY/HRESP_ERROR and HTRANS_IDLE/HTRANS_ACTIVE constants.
REQ-027 The storage array SHALL be a sub-module ahb_sram_regfile (sync write, async read, sync clear); the FSM and decode stay in ahb_sram_slave.

Verification
REQ-028 WAIT_STATES=0: write 32'hA5A5_0001 to BASE+0x4, then read BASE+0x4 back-to-back -> o_hrdata=32'hA5A5_0001 in the read data phase, o_hreadyout=1 in every cycle.
REQ-029 WAIT_STATES=3: read BASE+0x8 -> o_hreadyout low for exactly 3 cycles, then high with o_hrdata=0 (post-reset value).
REQ-030 Access to BASE+DEPTH*4 and to BASE+0x2 -> cycle 1 hreadyout=0/hresp=1, cycle 2 hreadyout=1/hresp=1; memory unchanged.
REQ-031 Error transfer followed by a transfer accepted during ERR2 to BASE+0x0 -> second transfer completes OKAY with no idle cycle between.
REQ-032 Reset asserted during WAIT of a write of 32'hDEAD_BEEF to BASE+0xC -> a later read of BASE+0xC returns 0.
REQ-033 Selected transfer with i_hready=0 held for 2 cycles -> not accepted, FSM stays IDLE; accepted on the first i_hready=1 edge.
